// File: rtl/lut_neuron_table_loader.sv
// Runtime-programmable truth-table neuron.
// A packed table arrives as a stream of config beats and is stored in a small
// distributed RAM. Lookups return the stored activation one cycle later. An
// unloaded table always answers 0.
module lut_neuron_table_loader #(
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 2,
  parameter int WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WORD_BITS-1:0] cfg_data,
  input  logic                 cfg_last,
  output logic                 cfg_err,
  output logic                 loaded,
  input  logic                 in_valid,
  input  logic [IN_BITS-1:0]   M0,
  output logic                 out_valid,
  output logic [OUT_BITS-1:0]  M1
);

  localparam int EPW       = WORD_BITS / OUT_BITS;
  localparam int LANE_BITS = $clog2(EPW);
  localparam int WORDS     = (2 ** IN_BITS) / EPW;
  localparam int WP_BITS   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WP_BITS-1:0] WP_LAST = WP_BITS'(WORDS - 1);

  typedef enum logic [1:0] {EMPTY, LOADING, READY, DRAIN} state_t;

  state_t               state;
  logic [WP_BITS-1:0]   wp;
  logic [WORD_BITS-1:0] ram [WORDS];

  logic                 beat_acc;
  logic                 ram_we;
  logic [WP_BITS-1:0]   wr_addr;
  logic [WP_BITS-1:0]   rd_addr;
  logic [WORD_BITS-1:0] rd_word;
  logic [OUT_BITS-1:0]  rd_entry;
  int                   rd_lane;

  // Write-side decode and asynchronous read of the addressed entry.
  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    beat_acc = cfg_valid & cfg_ready;
    ram_we   = beat_acc & (state != DRAIN) & ~rst;
    wr_addr  = (state == LOADING) ? wp : '0;
    rd_addr  = WP_BITS'(M0 >> LANE_BITS);
    rd_lane  = int'(M0) & (EPW - 1);
    rd_word  = ram[rd_addr];
    rd_entry = OUT_BITS'(rd_word >> (rd_lane * OUT_BITS));
  end

  // Table storage: one write port, no reset.
  // NOTE: the RAM is deliberately left unreset so it maps onto distributed RAM; loaded=0 masks stale contents.
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_addr] <= cfg_data;
  end

  // Load-sequencing FSM: tracks beat count, flags short/long loads, owns loaded.
  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      wp        <= '0;
      loaded    <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      if (beat_acc) begin
        case (state)
          EMPTY, READY: begin
            loaded <= 1'b0;
            if (WORDS == 1) begin
              wp <= '0;
              if (cfg_last) begin
                loaded <= 1'b1;
                state  <= READY;
              end else begin
                cfg_err <= 1'b1;
                state   <= DRAIN;
              end
            end else if (cfg_last) begin
              cfg_err <= 1'b1;
              wp      <= '0;
              state   <= EMPTY;
            end else begin
              wp    <= WP_BITS'(1);
              state <= LOADING;
            end
          end
          LOADING: begin
            wp <= wp + WP_BITS'(1);
            if (cfg_last) begin
              wp <= '0;
              if (wp == WP_LAST) begin
                loaded <= 1'b1;
                state  <= READY;
              end else begin
                cfg_err <= 1'b1;
                state   <= EMPTY;
              end
            end else if (wp == WP_LAST) begin
              cfg_err <= 1'b1;
              state   <= DRAIN;
            end
          end
          DRAIN: begin
            if (cfg_last) begin
              wp    <= '0;
              state <= EMPTY;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  // Registered lookup: one-cycle latency, result held when no request.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      M1        <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) M1 <= loaded ? rd_entry : '0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Directed bench for lut_neuron_table_loader with a load-level reference model.
module tb_lut_neuron_table_loader;

  localparam int WORDS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       cfg_err;
  logic       loaded;
  logic       in_valid;
  logic [7:0] M0;
  logic       out_valid;
  logic [1:0] M1;

  int checks = 0;
  int errors = 0;

  lut_neuron_table_loader #(.IN_BITS(8), .OUT_BITS(2), .WORD_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .cfg_err(cfg_err), .loaded(loaded),
    .in_valid(in_valid), .M0(M0), .out_valid(out_valid), .M1(M1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is a list of beats; it is committed whole only
  // when it ends with exactly WORDS beats. Lookups see the committed table.
  logic [1:0] tbl [256];
  logic [7:0] beats [WORDS];
  int         n_beats = 0;
  bit         started = 0;
  logic       m_ready = 0, m_loaded = 0, m_ov = 0, m_err = 0;
  logic [1:0] m_m1 = 0;

  always @(posedge clk) begin
    if (rst) begin
      started  = 1;
      m_ready  = 0;
      m_loaded = 0;
      m_ov     = 0;
      m_m1     = 0;
      m_err    = 0;
      n_beats  = 0;
    end else begin
      m_err = 0;
      m_ov  = in_valid;
      if (in_valid) m_m1 = m_loaded ? tbl[M0] : 2'b00;
      if (cfg_valid && m_ready) begin
        if (n_beats == 0) m_loaded = 0;
        if (n_beats < WORDS) beats[n_beats] = cfg_data;
        n_beats++;
        if (cfg_last) begin
          if (n_beats == WORDS) begin
            for (int w = 0; w < WORDS; w++)
              for (int k = 0; k < 4; k++)
                tbl[w*4 + k] = beats[w][k*2 +: 2];
            m_loaded = 1;
          end else if (n_beats < WORDS) begin
            m_err = 1;
          end
          n_beats = 0;
        end else if (n_beats == WORDS) begin
          m_err = 1;
        end
      end
      m_ready = 1;
    end
  end

  // Compare every DUT output against the model on the inactive edge.
  always @(negedge clk) begin
    if (started) begin
      check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
      check("cfg_err",   32'(cfg_err),   32'(m_err));
      check("loaded",    32'(loaded),    32'(m_loaded));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("M1",        32'(M1),        32'(m_m1));
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic iv, input logic [7:0] code);
    cfg_valid = v;
    cfg_data  = d;
    cfg_last  = l;
    in_valid  = iv;
    M0        = code;
    @(posedge clk);
    #1;
  endtask

  // Send n beats (data = base + i*step), cfg_last on beat last_idx,
  // optionally with a lookup of code i*7 alongside each beat.
  task automatic load(input int n, input int last_idx, input logic [7:0] base,
                      input logic [7:0] step, input bit lookups);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 8'(base + 8'(i) * step), 1'(i == last_idx), 1'(lookups), 8'(i * 7));
  endtask

  initial begin
    rst = 1'b1;
    cycle(0, 8'h00, 0, 0, 8'h00);
    cycle(0, 8'h00, 0, 1, 8'h00);
    check("rst_ready",  32'(cfg_ready), 32'd0);
    check("rst_loaded", 32'(loaded),    32'd0);
    check("rst_ov",     32'(out_valid), 32'd0);
    check("rst_m1",     32'(M1),        32'd0);
    rst = 1'b0;
    cycle(0, 8'h00, 0, 0, 8'h00);
    check("ready_after_rst", 32'(cfg_ready), 32'd1);

    // Full load of a constant 0,1,2,3 pattern.
    load(64, 63, 8'hE4, 8'h00, 1'b0);
    check("full_loaded", 32'(loaded), 32'd1);
    cycle(0, 8'h00, 0, 1, 8'hA7);
    check("lk_a7", 32'(M1), 32'd3);
    cycle(0, 8'h00, 0, 1, 8'h00);
    check("lk_00", 32'(M1), 32'd0);
    cycle(0, 8'h00, 0, 1, 8'h5E);
    check("lk_5e", 32'(M1), 32'd2);
    cycle(0, 8'h00, 0, 0, 8'h00);
    check("m1_hold", 32'(M1), 32'd2);

    // Short load ends on beat 10.
    load(11, 10, 8'hFF, 8'h00, 1'b0);
    check("short_err",    32'(cfg_err), 32'd1);
    check("short_loaded", 32'(loaded),  32'd0);
    cycle(0, 8'h00, 0, 1, 8'h03);
    check("short_ov", 32'(out_valid), 32'd1);
    check("short_m1", 32'(M1),        32'd0);

    // Long load: 70 beats, error after beat 63, tail discarded.
    for (int i = 0; i < 70; i++) begin
      cycle(1'b1, 8'hAA, 1'(i == 69), 1'b0, 8'h00);
      if (i == 63) check("long_err", 32'(cfg_err), 32'd1);
      if (i == 64) check("long_err_pulse", 32'(cfg_err), 32'd0);
    end
    check("long_loaded", 32'(loaded), 32'd0);
    load(64, 63, 8'd11, 8'd37, 1'b1);
    check("after_long_loaded", 32'(loaded), 32'd1);

    // Reload over a READY table with all-zero data.
    cycle(1'b1, 8'h00, 1'b0, 1'b1, 8'h40);
    check("reload_drop", 32'(loaded), 32'd0);
    load(63, 62, 8'h00, 8'h00, 1'b1);
    check("reload_loaded", 32'(loaded), 32'd1);
    for (int c = 0; c < 256; c++) cycle(0, 8'h00, 0, 1, 8'(c));

    // Reset at beat 30 of a load with a lookup in flight.
    load(30, -1, 8'd7, 8'd53, 1'b1);
    rst = 1'b1;
    cycle(1'b1, 8'h12, 1'b0, 1'b1, 8'h10);
    check("rst_mid_ov",     32'(out_valid), 32'd0);
    check("rst_mid_loaded", 32'(loaded),    32'd0);
    rst = 1'b0;
    cycle(0, 8'h00, 0, 0, 8'h00);
    load(63, -1, 8'd7, 8'd53, 1'b1);
    cycle(1'b1, 8'(8'd7 + 8'd63 * 8'd53), 1'b1, 1'b1, 8'h21);
    check("final_beat_ov",  32'(out_valid), 32'd1);
    check("final_beat_m1",  32'(M1),        32'd0);
    check("final_loaded",   32'(loaded),    32'd1);

    // Back-to-back sweep of every code.
    for (int c = 0; c < 256; c++) cycle(0, 8'h00, 0, 1, 8'(c));
    // Code 0x02: beat 0 data 8'd7 = 0000_0111, lane 2 -> 2'b00; code 0x05: beat 1
    // data 60 = 0011_1100, lane 1 -> 2'b11.
    cycle(0, 8'h00, 0, 1, 8'h05);
    check("lit_05", 32'(M1), 32'd3);
    cycle(0, 8'h00, 0, 1, 8'h01);
    check("lit_01", 32'(M1), 32'd1);
    cycle(0, 8'h00, 0, 0, 8'h00);
    cycle(0, 8'h00, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
